// File: rtl/rv32i_pkg.sv
// Shared definitions for the data-memory path: load/store width encodings,
// arbiter FSM states, port identifiers and the muxed memory request record.
package rv32i_pkg;

  // Load/store funct3 width encodings
  localparam logic [2:0] SIGNED_B  = 3'b000;
  localparam logic [2:0] SIGNED_H  = 3'b001;
  localparam logic [2:0] SIGNED_W  = 3'b010;
  localparam logic [2:0] USIGNED_B = 3'b100;
  localparam logic [2:0] USIGNED_H = 3'b101;

  typedef enum logic [0:0] {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DMA  = 1'b1;

  typedef struct packed {
    logic        we;
    logic [2:0]  width;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/dmem_access_check.sv
// Combinational legality check of one memory request: natural alignment for
// its width and word index inside the memory.
module dmem_access_check
  import rv32i_pkg::*;
#(
  parameter int DEPTH_WORDS = 200
) (
  input  logic [2:0]  width,
  input  logic [31:0] addr,
  output logic        misaligned,
  output logic        out_of_range,
  output logic        err
);

  always_comb begin
    misaligned = 1'b0;
    case (width)
      SIGNED_B, USIGNED_B: misaligned = 1'b0;
      SIGNED_H, USIGNED_H: misaligned = addr[0];
      SIGNED_W:            misaligned = (addr[1:0] != 2'b00);
      default:             misaligned = 1'b0;
    endcase
  end

  assign out_of_range = ({2'b00, addr[31:2]} >= 32'(DEPTH_WORDS));
  assign err          = misaligned | out_of_range;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port (core / DMA) round-robin arbiter in front of a single data memory,
// with DMA burst locking bounded by LOCK_MAX and one-cycle registered responses.
module dmem_arbiter
  import rv32i_pkg::*;
#(
  parameter int DEPTH_WORDS = 200,
  parameter int LOCK_MAX    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        c_valid,
  output logic        c_ready,
  input  logic        c_we,
  input  logic [2:0]  c_width,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic        c_rsp_valid,
  output logic [31:0] c_rsp_rdata,
  output logic        c_rsp_err,
  input  logic        d_valid,
  output logic        d_ready,
  input  logic        d_we,
  input  logic [2:0]  d_width,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic        d_lock,
  output logic        d_rsp_valid,
  output logic [31:0] d_rsp_rdata,
  output logic        d_rsp_err,
  output logic        mem_we,
  output logic [2:0]  mem_width,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  arb_state_e       state_q, state_d;
  logic             last_gnt_q, last_gnt_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;

  logic             c_rsp_valid_q, c_rsp_valid_d;
  logic             c_rsp_err_q, c_rsp_err_d;
  logic [31:0]      c_rsp_rdata_q, c_rsp_rdata_d;
  logic             d_rsp_valid_q, d_rsp_valid_d;
  logic             d_rsp_err_q, d_rsp_err_d;
  logic [31:0]      d_rsp_rdata_q, d_rsp_rdata_d;

  logic             gnt_c, gnt_d;
  mem_req_t         sel_req;
  logic             chk_misaligned, chk_out_of_range, chk_err;
  logic [31:0]      rsp_rdata;

  // Grant: LOCKED serves only the DMA; in ARB the port that did not win last
  // time takes a contended cycle.
  always_comb begin
    gnt_c = 1'b0;
    gnt_d = 1'b0;
    if (state_q == LOCKED) begin
      gnt_d = d_valid;
    end else if (c_valid && d_valid) begin
      if (last_gnt_q == PORT_CORE) gnt_d = 1'b1;
      else                         gnt_c = 1'b1;
    end else begin
      gnt_c = c_valid;
      gnt_d = d_valid;
    end
  end

  assign c_ready = gnt_c;
  assign d_ready = gnt_d;

  always_comb begin
    sel_req = '0;
    if (gnt_d) begin
      sel_req.we    = d_we;
      sel_req.width = d_width;
      sel_req.addr  = d_addr;
      sel_req.wdata = d_wdata;
    end else if (gnt_c) begin
      sel_req.we    = c_we;
      sel_req.width = c_width;
      sel_req.addr  = c_addr;
      sel_req.wdata = c_wdata;
    end
  end

  dmem_access_check #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_check (
    .width        (sel_req.width),
    .addr         (sel_req.addr),
    .misaligned   (chk_misaligned),
    .out_of_range (chk_out_of_range),
    .err          (chk_err)
  );

  // Illegal stores never reach the memory; other fields pass through as-is.
  assign mem_we    = sel_req.we & ~chk_err;
  assign mem_width = sel_req.width;
  assign mem_addr  = sel_req.addr;
  assign mem_wdata = sel_req.wdata;

  assign rsp_rdata = (sel_req.we || chk_err) ? 32'h0 : mem_rdata;

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    lock_cnt_d = lock_cnt_q;
    if (gnt_c) last_gnt_d = PORT_CORE;
    if (gnt_d) last_gnt_d = PORT_DMA;
    case (state_q)
      ARB: begin
        // The entering transfer is the first grant of the burst.
        if (gnt_d && d_lock && (LOCK_MAX > 1)) begin
          state_d    = LOCKED;
          lock_cnt_d = CNT_W'(1);
        end
      end
      LOCKED: begin
        if (gnt_d) lock_cnt_d = lock_cnt_q + CNT_W'(1);
        if (!d_lock) begin
          state_d    = ARB;
          lock_cnt_d = '0;
        end else if (gnt_d && ((lock_cnt_q + CNT_W'(1)) >= CNT_W'(LOCK_MAX))) begin
          state_d    = ARB;
          lock_cnt_d = '0;
          last_gnt_d = PORT_DMA;
        end
      end
      default: begin
        state_d    = ARB;
        lock_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    c_rsp_valid_d = gnt_c;
    c_rsp_err_d   = gnt_c & chk_err;
    c_rsp_rdata_d = gnt_c ? rsp_rdata : 32'h0;
    d_rsp_valid_d = gnt_d;
    d_rsp_err_d   = gnt_d & chk_err;
    d_rsp_rdata_d = gnt_d ? rsp_rdata : 32'h0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ARB;
      last_gnt_q    <= PORT_DMA;
      lock_cnt_q    <= '0;
      c_rsp_valid_q <= 1'b0;
      c_rsp_err_q   <= 1'b0;
      c_rsp_rdata_q <= 32'h0;
      d_rsp_valid_q <= 1'b0;
      d_rsp_err_q   <= 1'b0;
      d_rsp_rdata_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      last_gnt_q    <= last_gnt_d;
      lock_cnt_q    <= lock_cnt_d;
      c_rsp_valid_q <= c_rsp_valid_d;
      c_rsp_err_q   <= c_rsp_err_d;
      c_rsp_rdata_q <= c_rsp_rdata_d;
      d_rsp_valid_q <= d_rsp_valid_d;
      d_rsp_err_q   <= d_rsp_err_d;
      d_rsp_rdata_q <= d_rsp_rdata_d;
    end
  end

  assign c_rsp_valid = c_rsp_valid_q;
  assign c_rsp_err   = c_rsp_err_q;
  assign c_rsp_rdata = c_rsp_rdata_q;
  assign d_rsp_valid = d_rsp_valid_q;
  assign d_rsp_err   = d_rsp_err_q;
  assign d_rsp_rdata = d_rsp_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed bench for dmem_arbiter against a cycle-level
// reference model of grants, locking, memory contents and responses.
module tb_dmem_arbiter;
  import rv32i_pkg::*;

  localparam int DEPTH = 200;
  localparam int LMAX  = 8;

  typedef struct {
    bit          v;
    logic        we;
    logic [2:0]  w;
    logic [31:0] a;
    logic [31:0] wd;
  } req_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        c_valid = 1'b0, c_we = 1'b0, d_valid = 1'b0, d_we = 1'b0, d_lock = 1'b0;
  logic [2:0]  c_width = 3'd0, d_width = 3'd0;
  logic [31:0] c_addr = 32'h0, c_wdata = 32'h0, d_addr = 32'h0, d_wdata = 32'h0;
  logic        c_ready, d_ready, c_rsp_valid, d_rsp_valid, c_rsp_err, d_rsp_err, mem_we;
  logic [31:0] c_rsp_rdata, d_rsp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_width;

  logic [31:0] mem [DEPTH];
  logic        mem_init = 1'b1;
  logic [29:0] widx;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] ref_mem [DEPTH];
  int          m_locked, m_last, m_cnt;
  logic        exp_cv, exp_ce, exp_dv, exp_de;
  logic [31:0] exp_cr, exp_dr;

  always #5 clk = ~clk;

  dmem_arbiter #(.DEPTH_WORDS(DEPTH), .LOCK_MAX(LMAX)) dut (
    .clk(clk), .reset(reset),
    .c_valid(c_valid), .c_ready(c_ready), .c_we(c_we), .c_width(c_width),
    .c_addr(c_addr), .c_wdata(c_wdata),
    .c_rsp_valid(c_rsp_valid), .c_rsp_rdata(c_rsp_rdata), .c_rsp_err(c_rsp_err),
    .d_valid(d_valid), .d_ready(d_ready), .d_we(d_we), .d_width(d_width),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_lock(d_lock),
    .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata), .d_rsp_err(d_rsp_err),
    .mem_we(mem_we), .mem_width(mem_width), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] seed_word(input int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'h0BAD_F00D;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [2:0] w,
                                        input logic [1:0] off, input logic [31:0] wd);
    logic [31:0] r;
    r = old;
    case (w[1:0])
      2'b00:   r[off*8 +: 8] = wd[7:0];
      2'b01:   r[off[1]*16 +: 16] = wd[15:0];
      default: r = wd;
    endcase
    return r;
  endfunction

  assign widx      = mem_addr[31:2];
  assign mem_rdata = (widx < 30'(DEPTH)) ? mem[widx[7:0]] : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= seed_word(i);
    end else if (mem_we && (widx < 30'(DEPTH))) begin
      mem[widx[7:0]] <= merge(mem[widx[7:0]], mem_width, mem_addr[1:0], mem_wdata);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic req_t mk(input bit v, input logic we, input logic [2:0] w,
                              input logic [31:0] a, input logic [31:0] wd);
    req_t r;
    r.v = v; r.we = we; r.w = w; r.a = a; r.wd = wd;
    return r;
  endfunction

  function automatic req_t rnd_req(input bit v);
    req_t r;
    int   k, idx;
    r.v  = v;
    r.we = 1'($urandom_range(0, 1));
    if (r.we) r.w = 3'($urandom_range(0, 2));
    else begin
      k   = $urandom_range(0, 4);
      r.w = (k < 3) ? 3'(k) : 3'(k + 1);
    end
    idx = $urandom_range(0, DEPTH - 1);
    k   = $urandom_range(0, 9);
    if (k == 0) idx = DEPTH + $urandom_range(0, 60);
    r.a = {idx[29:0], 2'b00};
    if (k == 1) r.a[1:0] = 2'($urandom_range(0, 3));
    else if (r.w[1:0] == 2'b00) r.a[1:0] = 2'($urandom_range(0, 3));
    else if (r.w[1:0] == 2'b01) r.a[1] = 1'($urandom_range(0, 1));
    r.wd = $urandom;
    return r;
  endfunction

  // One clock cycle: check last cycle's responses, drive, check grant and
  // memory outputs, then advance the reference model past the posedge.
  task automatic step(input req_t c, input req_t d, input bit dl, input bit rst_mid,
                      output int gnt);
    int   g, idx;
    req_t s;
    bit   err;
    @(negedge clk);
    reset = 1'b0;
    check_eq("c_rsp_valid", 32'(c_rsp_valid), 32'(exp_cv));
    check_eq("c_rsp_err", 32'(c_rsp_err), 32'(exp_ce));
    check_eq("c_rsp_rdata", c_rsp_rdata, exp_cr);
    check_eq("d_rsp_valid", 32'(d_rsp_valid), 32'(exp_dv));
    check_eq("d_rsp_err", 32'(d_rsp_err), 32'(exp_de));
    check_eq("d_rsp_rdata", d_rsp_rdata, exp_dr);
    c_valid = c.v; c_we = c.we; c_width = c.w; c_addr = c.a; c_wdata = c.wd;
    d_valid = d.v; d_we = d.we; d_width = d.w; d_addr = d.a; d_wdata = d.wd;
    d_lock  = dl;
    #1;
    if (m_locked != 0)      g = d.v ? 2 : 0;
    else if (c.v && d.v)    g = (m_last == 1) ? 1 : 2;
    else                    g = c.v ? 1 : (d.v ? 2 : 0);
    check_eq("c_ready", 32'(c_ready), 32'(g == 1));
    check_eq("d_ready", 32'(d_ready), 32'(g == 2));
    s   = (g == 2) ? d : ((g == 1) ? c : mk(0, 0, 3'd0, 32'h0, 32'h0));
    idx = int'(s.a >> 2);
    err = (s.a >= 32'(DEPTH * 4)) ||
          ((s.w[1:0] == 2'b01) && s.a[0]) ||
          ((s.w[1:0] == 2'b10) && (s.a[1:0] != 2'b00));
    check_eq("mem_we", 32'(mem_we), 32'((g != 0) && s.we && !err));
    check_eq("mem_addr", mem_addr, s.a);
    check_eq("mem_wdata", mem_wdata, s.wd);
    check_eq("mem_width", 32'(mem_width), 32'(s.w));
    gnt = g;
    if (rst_mid) begin
      #1 reset = 1'b1;
      #1;
      check_eq("rst_c_rsp_valid", 32'(c_rsp_valid), 32'h0);
      check_eq("rst_d_rsp_valid", 32'(d_rsp_valid), 32'h0);
      check_eq("rst_c_rsp_rdata", c_rsp_rdata, 32'h0);
      check_eq("rst_d_rsp_rdata", d_rsp_rdata, 32'h0);
      $display("txn %0t reset during %s grant", $time, (g == 2) ? "dma" : "core");
      m_locked = 0; m_cnt = 0; m_last = 1;
      exp_cv = 0; exp_ce = 0; exp_cr = 0; exp_dv = 0; exp_de = 0; exp_dr = 0;
      return;
    end
    exp_cv = (g == 1);
    exp_ce = (g == 1) && err;
    exp_cr = ((g == 1) && !s.we && !err) ? ref_mem[idx] : 32'h0;
    exp_dv = (g == 2);
    exp_de = (g == 2) && err;
    exp_dr = ((g == 2) && !s.we && !err) ? ref_mem[idx] : 32'h0;
    if ((g != 0) && s.we && !err) ref_mem[idx] = merge(ref_mem[idx], s.w, s.a[1:0], s.wd);
    if (g != 0)
      $display("txn %0t %s we=%0b w=%0d addr=%08h err=%0b", $time,
               (g == 1) ? "core" : "dma ", s.we, s.w, s.a, err);
    if (g == 1) m_last = 0;
    if (g == 2) m_last = 1;
    if (m_locked != 0) begin
      if (g == 2) m_cnt++;
      if (!dl) begin
        m_locked = 0; m_cnt = 0;
      end else if (m_cnt >= LMAX) begin
        m_locked = 0; m_cnt = 0; m_last = 1;
      end
    end else if ((g == 2) && dl) begin
      m_locked = 1; m_cnt = 1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   g;
    req_t idle, rc, rd;
    idle = mk(0, 0, 3'd0, 32'h0, 32'h0);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = seed_word(i);
    m_locked = 0; m_last = 1; m_cnt = 0;
    exp_cv = 0; exp_ce = 0; exp_cr = 0; exp_dv = 0; exp_de = 0; exp_dr = 0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    mem_init = 1'b0;
    check_eq("reset_c_rsp_valid", 32'(c_rsp_valid), 32'h0);
    check_eq("reset_d_rsp_valid", 32'(d_rsp_valid), 32'h0);
    check_eq("reset_c_rsp_err", 32'(c_rsp_err), 32'h0);
    check_eq("reset_d_rsp_rdata", d_rsp_rdata, 32'h0);
    step(idle, idle, 0, 0, g);

    // Contention from reset: core first, then strict alternation.
    for (int i = 0; i < 6; i++) begin
      step(rnd_req(1), rnd_req(1), 0, 0, g);
      check_eq("contend_gnt", 32'(g), (i % 2 == 0) ? 32'd1 : 32'd2);
    end

    // Lock limit: a core-only cycle makes the DMA the next contention winner.
    step(rnd_req(1), idle, 0, 0, g);
    for (int i = 0; i < 12; i++) begin
      rd = mk(1, 0, SIGNED_W, 32'(i * 4), 32'h0);
      step(mk(1, 0, SIGNED_W, 32'h100, 32'h0), rd, 1, 0, g);
      check_eq("lock_gnt", 32'(g), (i < 8) ? 32'd2 : ((i == 8) ? 32'd1 : 32'd2));
    end
    step(rnd_req(1), rnd_req(1), 0, 0, g);
    check_eq("unlock_last_dma", 32'(g), 32'd2);
    step(idle, idle, 0, 0, g);

    // Out-of-range core store.
    step(mk(1, 1, SIGNED_W, 32'h0000_0320, 32'hCAFE_F00D), idle, 0, 0, g);
    check_eq("range_mem_we", 32'(mem_we), 32'h0);
    @(posedge clk); #1;
    check_eq("range_rsp_err", 32'(c_rsp_err), 32'h1);
    check_eq("range_rsp_rdata", c_rsp_rdata, 32'h0);

    // Misaligned DMA halfword, then aligned word read.
    step(idle, mk(1, 0, SIGNED_H, 32'h0000_0065, 32'h0), 0, 0, g);
    @(posedge clk); #1;
    check_eq("misal_rsp_err", 32'(d_rsp_err), 32'h1);
    check_eq("misal_c_quiet", 32'(c_rsp_valid), 32'h0);
    step(idle, mk(1, 0, SIGNED_W, 32'h0000_0064, 32'h0), 0, 0, g);
    @(posedge clk); #1;
    check_eq("word_rsp_err", 32'(d_rsp_err), 32'h0);
    check_eq("word_rsp_rdata", d_rsp_rdata, ref_mem[25]);

    // Reset during the third locked DMA grant.
    step(rnd_req(1), idle, 0, 0, g);
    for (int i = 0; i < 3; i++) begin
      rc = mk(1, 0, USIGNED_B, 32'h0000_0013, 32'h0);
      rd = mk(1, 0, SIGNED_W, 32'(32'h40 + i * 4), 32'h0);
      step(rc, rd, 1, (i == 2), g);
      check_eq("pre_rst_gnt", 32'(g), 32'd2);
    end
    step(rnd_req(1), rnd_req(1), 0, 0, g);
    check_eq("rst_core_first", 32'(g), 32'd1);

    // Randomized traffic with occasional lock requests.
    for (int i = 0; i < 400; i++) begin
      rc = rnd_req($urandom_range(0, 3) != 0);
      rd = rnd_req($urandom_range(0, 3) != 0);
      step(rc, rd, $urandom_range(0, 3) == 0, 0, g);
    end
    step(idle, idle, 0, 0, g);
    step(idle, idle, 0, 0, g);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
